// File: rtl/rvv_instr_encoder.sv
// Turns structured vector-op requests into 32-bit RVV instruction words.
// The config word (vsetivli/vsetvli) is only issued when the cached vtype/AVL pair changes.
module rvv_instr_encoder #(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [31:0]         req_avl_i,
    input  logic [4:0]          req_avl_reg_i,
    input  logic [7:0]          req_vtype_i,
    input  logic [5:0]          req_func6_i,
    input  logic [2:0]          req_func3_i,
    input  logic                req_vm_i,
    input  logic [4:0]          req_vd_i,
    input  logic [4:0]          req_vs1_i,
    input  logic [4:0]          req_vs2_i,
    input  logic                flush_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [31:0]         instr_o,
    output logic                illegal_o,
    output logic [CntWidth-1:0] emitted_cnt_o,
    output logic [CntWidth-1:0] cfg_skip_cnt_o
);

    localparam logic [6:0] OPCODE_V  = 7'b1010111;
    localparam logic [2:0] FUNC3_CFG = 3'b111;
    localparam logic [2:0] LMUL_RSVD = 3'b100;
    localparam logic [2:0] EW64      = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        CFG,
        ARITH
    } state_t;

    state_t state, state_next;

    logic [31:0] lat_avl;
    logic [4:0]  lat_avl_reg;
    logic [7:0]  lat_vtype;
    logic [5:0]  lat_func6;
    logic [2:0]  lat_func3;
    logic        lat_vm;
    logic [4:0]  lat_vd;
    logic [4:0]  lat_vs1;
    logic [4:0]  lat_vs2;

    logic        cache_valid;
    logic [7:0]  cache_vtype;
    logic [31:0] cache_avl;

    logic accept;
    logic handshake;
    logic req_illegal;
    logic cache_hit;

    function automatic logic [31:0] cfg_word(input logic [31:0] avl,
                                             input logic [4:0]  avl_reg,
                                             input logic [7:0]  vtype);
        logic [31:0] word;
        // Short AVLs fit the immediate form; longer ones come from a scalar register.
        if (avl < 32'd32) begin
            word = {2'b11, 2'b00, vtype, avl[4:0], FUNC3_CFG, 5'd0, OPCODE_V};
        end else begin
            word = {1'b0, 3'b000, vtype, avl_reg, FUNC3_CFG, 5'd0, OPCODE_V};
        end
        return word;
    endfunction

    function automatic logic [31:0] arith_word(input logic [5:0] func6,
                                               input logic       vm,
                                               input logic [4:0] vs2,
                                               input logic [4:0] vs1,
                                               input logic [2:0] func3,
                                               input logic [4:0] vd);
        return {func6, vm, vs2, vs1, func3, vd, OPCODE_V};
    endfunction

    assign req_ready_o = (state == IDLE);
    assign accept      = req_valid_i && req_ready_o;
    assign handshake   = instr_valid_o && instr_ready_i;

    assign req_illegal = (req_vtype_i[2:0] == LMUL_RSVD) ||
                         (req_vtype_i[5:3] > EW64) ||
                         (req_func3_i == FUNC3_CFG);

    assign cache_hit = cache_valid &&
                       (req_vtype_i == cache_vtype) &&
                       (req_avl_i == cache_avl);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !req_illegal) begin
                    state_next = cache_hit ? ARITH : CFG;
                end
            end
            CFG: begin
                if (handshake) begin
                    state_next = ARITH;
                end
            end
            ARITH: begin
                if (handshake) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            instr_valid_o  <= 1'b0;
            instr_o        <= '0;
            illegal_o      <= 1'b0;
            emitted_cnt_o  <= '0;
            cfg_skip_cnt_o <= '0;
            cache_valid    <= 1'b0;
            cache_vtype    <= '0;
            cache_avl      <= '0;
            lat_avl        <= '0;
            lat_avl_reg    <= '0;
            lat_vtype      <= '0;
            lat_func6      <= '0;
            lat_func3      <= '0;
            lat_vm         <= 1'b0;
            lat_vd         <= '0;
            lat_vs1        <= '0;
            lat_vs2        <= '0;
        end else begin
            state     <= state_next;
            illegal_o <= accept && req_illegal;

            if (accept) begin
                lat_avl     <= req_avl_i;
                lat_avl_reg <= req_avl_reg_i;
                lat_vtype   <= req_vtype_i;
                lat_func6   <= req_func6_i;
                lat_func3   <= req_func3_i;
                lat_vm      <= req_vm_i;
                lat_vd      <= req_vd_i;
                lat_vs1     <= req_vs1_i;
                lat_vs2     <= req_vs2_i;
            end

            // The word is loaded straight from the request so it is valid one cycle after accept.
            case (state)
                IDLE: begin
                    if (accept && !req_illegal) begin
                        instr_valid_o <= 1'b1;
                        if (cache_hit) begin
                            instr_o        <= arith_word(req_func6_i, req_vm_i, req_vs2_i,
                                                         req_vs1_i, req_func3_i, req_vd_i);
                            cfg_skip_cnt_o <= cfg_skip_cnt_o + CntWidth'(1);
                        end else begin
                            instr_o <= cfg_word(req_avl_i, req_avl_reg_i, req_vtype_i);
                        end
                    end
                end
                CFG: begin
                    if (handshake) begin
                        instr_o     <= arith_word(lat_func6, lat_vm, lat_vs2,
                                                  lat_vs1, lat_func3, lat_vd);
                        cache_valid <= 1'b1;
                        cache_vtype <= lat_vtype;
                        cache_avl   <= lat_avl;
                    end
                end
                ARITH: begin
                    if (handshake) begin
                        instr_valid_o <= 1'b0;
                    end
                end
                default: instr_valid_o <= 1'b0;
            endcase

            if (handshake) begin
                emitted_cnt_o <= emitted_cnt_o + CntWidth'(1);
            end

            // Placed last so a flush overrides a cache fill in the same cycle.
            if (flush_i) begin
                cache_valid <= 1'b0;
            end
        end
    end

endmodule
